packet_dispatch_14out: RTL and testbench

PACKET_DISPATCH_14OUT -- requirements
Module: packet_dispatch_14out

---
 rtl/packet_dispatch_14out_pkg.sv | 23 ++
 rtl/packet_dispatch_14out_sync_fifo.sv | 58 +++++
 rtl/packet_dispatch_14out.sv | 86 ++++++++
 tb/tb_packet_dispatch_14out.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/packet_dispatch_14out_pkg.sv
// Shared packet layout, default dispatch geometry and the dispatch FSM state type.
package packet_dispatch_14out_pkg;

    localparam int PKT_WIDTH   = 8;
    localparam int PKT_DEST_W  = 4;
    localparam int PKT_NUM_OUT = 14;

    typedef struct packed {
        logic [PKT_DEST_W-1:0]           dest;
        logic [PKT_WIDTH-PKT_DEST_W-1:0] payload;
    } packet_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PRESENT = 2'd1,
        ST_DROP    = 2'd2
    } dispatch_state_e;

    function automatic logic [PKT_DEST_W-1:0] pkt_dest(input packet_t p);
        return p.dest;
    endfunction

endpackage

// File: rtl/packet_dispatch_14out_sync_fifo.sv
// Circular buffer with occupancy count; also exposes next-cycle count and head
// so the dispatcher can register its outputs without adding a cycle of latency.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] count_nxt,
    output logic [WIDTH-1:0]           head_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // When the slot being written this edge becomes the head, forward it.
    always_comb begin
        rd_ptr_nxt = rd_ptr + AW'(do_pop);
        count_nxt  = count + CW'(do_push) - CW'(do_pop);
        head_nxt   = mem[rd_ptr_nxt];
        if (do_push && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/packet_dispatch_14out.sv
// Buffers arbitrated packets and presents the head to the one output port its
// destination field names; packets with an out-of-range destination are dropped.
module packet_dispatch_14out
    import packet_dispatch_14out_pkg::*;
#(
    parameter int WIDTH   = PKT_WIDTH,
    parameter int DEST_W  = PKT_DEST_W,
    parameter int NUM_OUT = PKT_NUM_OUT,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic [NUM_OUT-1:0]         out_valid,
    input  logic [NUM_OUT-1:0]         out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [7:0]                 drop_cnt,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output dispatch_state_e            dbg_state
);

    localparam int CW = $clog2(DEPTH+1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid/data hold steady until that edge, ready never depends on valid.

    logic              push;
    logic              pop;
    logic [CW-1:0]     count_nxt;
    logic [WIDTH-1:0]  head_nxt;
    logic [DEST_W-1:0] dest_nxt;
    dispatch_state_e   state_q;

    assign push      = in_valid && in_ready;
    assign pop       = (state_q == ST_DROP) ||
                       ((state_q == ST_PRESENT) && |(out_valid & out_ready));
    assign dest_nxt  = head_nxt[WIDTH-1 -: DEST_W];
    assign dbg_state = state_q;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .wr_data   (in_data),
        .count     (fifo_count),
        .count_nxt (count_nxt),
        .head_nxt  (head_nxt)
    );

    // State and outputs are computed from next-cycle occupancy and head so a
    // packet pushed on one edge is presented in the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            out_valid <= '0;
            out_data  <= '0;
            drop_cnt  <= '0;
            in_ready  <= 1'b0;
        end else begin
            in_ready <= (count_nxt < CW'(DEPTH));
            if ((state_q == ST_DROP) && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (count_nxt == '0) begin
                state_q   <= ST_EMPTY;
                out_valid <= '0;
            end else begin
                out_data <= head_nxt;
                if (int'(dest_nxt) < NUM_OUT) begin
                    state_q   <= ST_PRESENT;
                    out_valid <= {{(NUM_OUT-1){1'b0}}, 1'b1} << dest_nxt;
                end else begin
                    state_q   <= ST_DROP;
                    out_valid <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_packet_dispatch_14out.sv
// Directed bench for packet_dispatch_14out with a scoreboard of expected delivered packets.
module tb_packet_dispatch_14out;
    import packet_dispatch_14out_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [13:0] out_valid;
    logic [13:0] out_ready;
    logic [7:0]  out_data;
    logic [7:0]  drop_cnt;
    logic [2:0]  fifo_count;
    dispatch_state_e dbg_state;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    packet_dispatch_14out dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_cnt   (drop_cnt),
        .fifo_count (fifo_count),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [7:0] d, input bit deliver);
        in_valid = 1'b1;
        in_data  = d;
        if (deliver) exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        check({tag, "_drained"}, exp_q.size(), 0);
        tick();
        check({tag, "_count0"}, fifo_count, 0);
        check({tag, "_valid0"}, out_valid, 0);
    endtask

    // scoreboard: a pop happens on the next rising edge when the selected port is ready
    always @(negedge clk) begin
        if (rst_n && |(out_valid & out_ready)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                logic [13:0] exp_v;
                e = exp_q.pop_front();
                exp_v = 14'd1 << e[7:4];
                check("sb_data", out_data, e);
                check("sb_valid", out_valid, exp_v);
            end
        end
    end

    initial begin
        logic [7:0] d;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = '0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_count", fifo_count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // single packet to port 3
        out_ready = '1;
        push_pkt(8'h35, 1'b1);
        check("single_valid", out_valid, 14'd1 << 3);
        check("single_data", out_data, 8'h35);
        tick();
        check("single_count0", fifo_count, 0);
        check("single_valid0", out_valid, 0);

        // fill to full, then a rejected fifth packet
        out_ready = '0;
        push_pkt(8'h01, 1'b1);
        push_pkt(8'h12, 1'b1);
        push_pkt(8'h23, 1'b1);
        push_pkt(8'h34, 1'b1);
        check("full_count", fifo_count, 4);
        check("full_in_ready", in_ready, 0);
        push_pkt(8'h45, 1'b0);
        check("full_reject_count", fifo_count, 4);
        check("full_head_data", out_data, 8'h01);
        out_ready = '1;
        drain("fill");

        // invalid destinations are dropped silently
        push_pkt(8'hE7, 1'b0);
        push_pkt(8'hF0, 1'b0);
        push_pkt(8'h5A, 1'b1);
        drain("drop");
        check("drop_cnt2", drop_cnt, 2);

        // saturation of the drop counter
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            in_data = {4'(14 + (i % 2)), 4'(i)};
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("drop_sat", drop_cnt, 255);
        check("drop_sat_count", fifo_count, 0);

        // steady stream at occupancy 2
        out_ready = '0;
        for (int i = 0; i < 2; i++) begin
            d = {4'($urandom_range(0, 13)), 4'($urandom_range(0, 15))};
            push_pkt(d, 1'b1);
        end
        check("stream_pre_count", fifo_count, 2);
        out_ready = '1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d = {4'($urandom_range(0, 13)), 4'($urandom_range(0, 15))};
            in_data = d;
            exp_q.push_back(d);
            tick();
            check("stream_count", fifo_count, 2);
        end
        in_valid = 1'b0;
        drain("stream");

        // head-of-line hold: wrong port ready does not pop
        out_ready = '0;
        push_pkt(8'h4C, 1'b1);
        out_ready = 14'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_data", out_data, 8'h4C);
            check("hold_valid", out_valid, 14'd1 << 4);
            check("hold_count", fifo_count, 1);
        end
        out_ready[4] = 1'b1;
        drain("hold");

        // asynchronous reset with packets buffered
        out_ready = '0;
        push_pkt(8'h11, 1'b0);
        push_pkt(8'h22, 1'b0);
        push_pkt(8'h33, 1'b0);
        check("pre_rst_count", fifo_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_in_ready", in_ready, 0);
        #3;
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1);
        check("rel_count", fifo_count, 0);
        out_ready = '1;
        push_pkt(8'h2B, 1'b1);
        check("rel_valid", out_valid, 14'd1 << 2);
        drain("rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
